// File: rtl/aesl_dl_pkg.sv
// Shared types, defaults and the rotating first-set-bit search for the deadlock origin arbiter.
package aesl_dl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        CLEAR  = 2'd2,
        REPORT = 2'd3
    } dl_state_t;

    localparam int unsigned DL_PROC_NUM      = 2;
    localparam int unsigned DL_ID_W          = 1;
    localparam int unsigned DL_STABLE_CYCLES = 4;
    localparam int unsigned DL_PROBE_TIMEOUT = 16;
    localparam int unsigned DL_CNT_W         = 16;

    // Search width bound; callers zero-extend their vectors to this size.
    localparam int unsigned RR_MAX_PROC = 64;
    localparam int unsigned RR_IDX_W    = 6;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_first_set(
        input logic [RR_MAX_PROC-1:0] vec,
        input int unsigned            n,
        input logic [RR_IDX_W-1:0]    start
    );
        rr_pick_t    r;
        int unsigned j;
        r.found = 1'b0;
        r.idx   = '0;
        j       = 0;
        for (int unsigned k = 0; k < RR_MAX_PROC; k++) begin
            if (k < n) begin
                j = 32'(start) + k;
                if (j >= n) j = j - n;
                if (!r.found && vec[j[RR_IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[RR_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aesl_dl_rr_picker.sv
// Combinational round-robin selector: first set bit of i_vec at or after i_start, wrapping.
import aesl_dl_pkg::*;

module aesl_dl_rr_picker #(
    parameter int unsigned PROC_NUM = DL_PROC_NUM,
    parameter int unsigned ID_W     = DL_ID_W
) (
    input  logic [PROC_NUM-1:0] i_vec,
    input  logic [ID_W-1:0]     i_start,
    output logic [ID_W-1:0]     o_idx,
    output logic                o_found
);

    rr_pick_t w_pick;

    always_comb begin
        w_pick  = rr_first_set(RR_MAX_PROC'(i_vec), PROC_NUM, RR_IDX_W'(i_start));
        o_found = w_pick.found;
        o_idx   = ID_W'(w_pick.idx);
    end

endmodule

// File: rtl/aesl_deadlock_origin_arbiter.sv
// Elects one probe origin at a time, times out stale probes, latches a sticky deadlock verdict.
// Optional simulation report on verdict: define AESL_DL_REPORT_DISPLAY_EN.
import aesl_dl_pkg::*;

module aesl_deadlock_origin_arbiter #(
    parameter int unsigned PROC_NUM      = DL_PROC_NUM,
    parameter int unsigned ID_W          = DL_ID_W,
    parameter int unsigned STABLE_CYCLES = DL_STABLE_CYCLES,
    parameter int unsigned PROBE_TIMEOUT = DL_PROBE_TIMEOUT,
    parameter int unsigned CNT_W         = DL_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] blocked_vec,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                dl_detect_out,
    output logic [ID_W-1:0]     dl_origin_id,
    output logic [CNT_W-1:0]    probe_cnt
);

    localparam int unsigned SC_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TM_W = $clog2(PROBE_TIMEOUT);
    localparam logic [PROC_NUM-1:0] ONE_HOT0 = PROC_NUM'(1);

    dl_state_t           r_state;
    logic [PROC_NUM-1:0] r_prev_blk;
    logic [SC_W-1:0]     r_stable_cnt;
    logic [TM_W-1:0]     r_timer;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_origin_idx;

    logic [ID_W-1:0]     w_sel;
    logic                w_found;
    logic                w_stable_hit;
    logic                w_confirm;

    aesl_dl_rr_picker #(
        .PROC_NUM (PROC_NUM),
        .ID_W     (ID_W)
    ) u_picker (
        .i_vec   (blocked_vec),
        .i_start (r_rr_ptr),
        .o_idx   (w_sel),
        .o_found (w_found)
    );

    assign w_stable_hit = (blocked_vec != '0) && (blocked_vec == r_prev_blk);
    assign w_confirm    = (r_state == PROBE) && dl_in_vec[r_origin_idx];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_prev_blk    <= '0;
            r_stable_cnt  <= '0;
            r_timer       <= '0;
            r_rr_ptr      <= '0;
            r_origin_idx  <= '0;
            origin        <= '0;
            token_clear   <= 1'b0;
            dl_detect_out <= 1'b0;
            dl_origin_id  <= '0;
            probe_cnt     <= '0;
        end else begin
            r_prev_blk  <= blocked_vec;
            token_clear <= 1'b0;
            case (r_state)
                IDLE: begin
                    origin <= '0;
                    if (w_stable_hit) begin
                        if (r_stable_cnt == SC_W'(STABLE_CYCLES - 1) && w_found) begin
                            origin       <= ONE_HOT0 << w_sel;
                            r_origin_idx <= w_sel;
                            r_timer      <= '0;
                            r_stable_cnt <= '0;
                            r_state      <= PROBE;
                            if (probe_cnt != '1) probe_cnt <= probe_cnt + 1'b1;
                        end else if (r_stable_cnt != SC_W'(STABLE_CYCLES)) begin
                            r_stable_cnt <= r_stable_cnt + 1'b1;
                        end
                    end else begin
                        r_stable_cnt <= '0;
                    end
                end
                PROBE: begin
                    // Confirmation outranks both unblock and timeout.
                    if (w_confirm) begin
                        dl_detect_out <= 1'b1;
                        dl_origin_id  <= r_origin_idx;
                        r_state       <= REPORT;
                    end else if (!blocked_vec[r_origin_idx] ||
                                 r_timer == TM_W'(PROBE_TIMEOUT - 1)) begin
                        token_clear <= 1'b1;
                        origin      <= '0;
                        r_rr_ptr    <= (r_origin_idx == ID_W'(PROC_NUM - 1)) ? '0
                                                                             : r_origin_idx + 1'b1;
                        r_state     <= CLEAR;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                CLEAR: begin
                    r_stable_cnt <= '0;
                    r_state      <= IDLE;
                end
                REPORT: begin
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef AESL_DL_REPORT_DISPLAY_EN
    logic [31:0] r_cyc;
    logic [1:0]  r_fin_pipe;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cyc      <= '0;
            r_fin_pipe <= '0;
        end else begin
            r_cyc      <= r_cyc + 32'd1;
            r_fin_pipe <= {r_fin_pipe[0], w_confirm};
            if (w_confirm)
                $display("aesl_dl: deadlock origin=%0d probe_cnt=%0d cycle=%0d",
                         r_origin_idx, probe_cnt, r_cyc);
            if (r_fin_pipe[1]) $finish;
        end
    end
`else
    // Synthesis build: no report counter, no simulation side effects.
`endif

endmodule

// File: tb/tb_aesl_deadlock_origin_arbiter.sv
// Directed self-checking bench for aesl_deadlock_origin_arbiter (PROC_NUM=2, STABLE=4, TIMEOUT=16).
module tb_aesl_deadlock_origin_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  blocked_vec;
    logic [1:0]  dl_in_vec;
    logic [1:0]  origin;
    logic        token_clear;
    logic        dl_detect_out;
    logic [0:0]  dl_origin_id;
    logic [15:0] probe_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int n_tc     = 0;

    aesl_deadlock_origin_arbiter #(
        .PROC_NUM      (2),
        .ID_W          (1),
        .STABLE_CYCLES (4),
        .PROBE_TIMEOUT (16),
        .CNT_W         (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .blocked_vec   (blocked_vec),
        .dl_in_vec     (dl_in_vec),
        .origin        (origin),
        .token_clear   (token_clear),
        .dl_detect_out (dl_detect_out),
        .dl_origin_id  (dl_origin_id),
        .probe_cnt     (probe_cnt)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        n_tc += int'(token_clear);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_origin"}, 32'(origin), 32'd0);
        chk({tag, "_tclr"},   32'(token_clear), 32'd0);
        chk({tag, "_dl"},     32'(dl_detect_out), 32'd0);
        chk({tag, "_id"},     32'(dl_origin_id), 32'd0);
        chk({tag, "_cnt"},    32'(probe_cnt), 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        blocked_vec = 2'b00;
        dl_in_vec   = 2'b00;
        step();
        step();
        chk_reset_vals("rst");

        // Stable window then first probe on origin 0
        reset       = 1'b1;
        blocked_vec = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("win_origin", 32'(origin), 32'd0);
        end
        step();
        chk("p1_origin", 32'(origin), 32'h1);
        chk("p1_cnt", 32'(probe_cnt), 32'd1);
        chk("p1_tc_none", 32'(n_tc), 32'd0);

        // Confirm at timer=3, verdict sticky for 50 cycles
        step(); step(); step();
        dl_in_vec = 2'b01;
        step();
        chk("rep_dl", 32'(dl_detect_out), 32'd1);
        chk("rep_id", 32'(dl_origin_id), 32'd0);
        chk("rep_origin", 32'(origin), 32'h1);
        for (int i = 0; i < 50; i++) begin
            blocked_vec = 2'($urandom_range(0, 3));
            dl_in_vec   = 2'($urandom_range(0, 3));
            step();
            chk("rep_hold_dl", 32'(dl_detect_out), 32'd1);
            chk("rep_hold_origin", 32'(origin), 32'h1);
        end
        chk("rep_tc_none", 32'(n_tc), 32'd0);
        chk("rep_cnt", 32'(probe_cnt), 32'd1);

        // Timeout path with both processes blocked, round-robin to origin 1
        reset       = 1'b0;
        blocked_vec = 2'b11;
        dl_in_vec   = 2'b00;
        step();
        chk_reset_vals("rst2");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        step();
        chk("to_origin0", 32'(origin), 32'h1);
        dl_in_vec = 2'b10;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_wait_tc", 32'(token_clear), 32'd0);
            chk("to_wait_origin", 32'(origin), 32'h1);
        end
        step();
        chk("to_tc", 32'(token_clear), 32'd1);
        chk("to_clr_origin", 32'(origin), 32'd0);
        chk("to_dl", 32'(dl_detect_out), 32'd0);
        dl_in_vec = 2'b00;
        step();
        chk("to_tc_fall", 32'(token_clear), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rr_win_origin", 32'(origin), 32'd0);
        end
        step();
        chk("rr_origin1", 32'(origin), 32'h2);
        chk("rr_cnt", 32'(probe_cnt), 32'd2);
        chk("rr_tc_count", 32'(n_tc), 32'd1);

        // Origin 1 unblocks -> clear, then toggling blocked never stabilises
        blocked_vec = 2'b01;
        step();
        chk("ub_tc", 32'(token_clear), 32'd1);
        chk("ub_origin", 32'(origin), 32'd0);
        for (int i = 0; i < 20; i++) begin
            blocked_vec = (((i / 2) % 2) == 0) ? 2'b10 : 2'b01;
            step();
            chk("tog_origin", 32'(origin), 32'd0);
        end
        chk("tog_tc_count", 32'(n_tc), 32'd2);
        chk("tog_cnt", 32'(probe_cnt), 32'd2);

        // Reset mid-probe, then a fresh full stability window
        reset       = 1'b0;
        blocked_vec = 2'b01;
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        step();
        chk("mp_origin", 32'(origin), 32'h1);
        step(); step();
        reset = 1'b0;
        step();
        chk_reset_vals("mp_rst");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mp_win_origin", 32'(origin), 32'd0);
        end
        step();
        chk("mp_reprobe", 32'(origin), 32'h1);
        chk("mp_cnt", 32'(probe_cnt), 32'd1);

        // Confirm and unblock in the same cycle
        dl_in_vec   = 2'b01;
        blocked_vec = 2'b00;
        step();
        chk("sim_dl", 32'(dl_detect_out), 32'd1);
        chk("sim_id", 32'(dl_origin_id), 32'd0);
        chk("sim_tc", 32'(token_clear), 32'd0);
        chk("sim_origin", 32'(origin), 32'h1);
        step(); step();
        chk("sim_tc_count", 32'(n_tc), 32'd2);

        // Origin 1: confirm coincides with unblock and timeout expiry
        reset       = 1'b0;
        blocked_vec = 2'b10;
        dl_in_vec   = 2'b00;
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        step();
        chk("o1_origin", 32'(origin), 32'h2);
        dl_in_vec = 2'b01;
        for (int i = 0; i < 15; i++) step();
        chk("o1_ignored_dl", 32'(dl_detect_out), 32'd0);
        chk("o1_still_origin", 32'(origin), 32'h2);
        dl_in_vec   = 2'b10;
        blocked_vec = 2'b00;
        step();
        chk("o1_dl", 32'(dl_detect_out), 32'd1);
        chk("o1_id", 32'(dl_origin_id), 32'd1);
        chk("o1_tc", 32'(token_clear), 32'd0);
        chk("o1_tc_count", 32'(n_tc), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
